// File: rtl/dcache_tag_array.sv
// Multi-way tag store for the write-back data cache: registered lookup with hit
// detection, masked write-first updates and a sequential invalidate-all sweep.
module dcache_tag_array #(
    parameter int NUM_WAYS  = 2,
    parameter int NUM_SETS  = 64,
    parameter int TAG_WIDTH = 20,
    parameter int IDX_W     = $clog2(NUM_SETS),
    parameter int ENT_W     = TAG_WIDTH + 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    output logic                      req_ready_o,
    input  logic [IDX_W-1:0]          index_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    input  logic [NUM_WAYS-1:0]       wr_en_i,
    input  logic [TAG_WIDTH-1:0]      wtag_i,
    input  logic                      wvalid_i,
    input  logic                      wdirty_i,
    input  logic                      flush_i,
    output logic                      busy_o,
    output logic                      rsp_valid_o,
    output logic                      hit_o,
    output logic [NUM_WAYS-1:0]       hit_way_o,
    output logic [NUM_WAYS*ENT_W-1:0] rdata_o
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             sweep;
    logic             last_set;
    logic             req_fire;

    // Valid/dirty live apart from the tags so a sweep can clear them without a tag write.
    logic [NUM_WAYS-1:0]  valid_mem [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_mem [NUM_SETS];
    logic [TAG_WIDTH-1:0] tag_mem   [NUM_SETS][NUM_WAYS];

    logic [NUM_WAYS*ENT_W-1:0] rd_entries;
    logic [NUM_WAYS*ENT_W-1:0] rdata_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic                      rsp_valid_q;
    logic [NUM_WAYS-1:0]       hit_way;

    assign sweep       = (state_q == ST_INIT) || (state_q == ST_FLUSH);
    assign last_set    = (cnt_q == IDX_W'(NUM_SETS - 1));
    assign req_ready_o = (state_q == ST_IDLE) && !flush_i && !rst;
    assign req_fire    = req_i && req_ready_o;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                if (last_set) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // NOTE: the arrays have no reset; the post-reset sweep is what invalidates them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep) begin
                valid_mem[cnt_q] <= '0;
                dirty_mem[cnt_q] <= '0;
            end else if (req_fire) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (wr_en_i[w]) begin
                        valid_mem[index_i][w] <= wvalid_i;
                        dirty_mem[index_i][w] <= wdirty_i;
                        tag_mem[index_i][w]   <= wtag_i;
                    end
                end
            end
        end
    end

    // Write-first: a way being written returns the new entry in the same response.
    always_comb begin
        rd_entries = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (wr_en_i[w]) begin
                rd_entries[w*ENT_W +: ENT_W] = {wvalid_i, wdirty_i, wtag_i};
            end else begin
                rd_entries[w*ENT_W +: ENT_W] = {valid_mem[index_i][w],
                                                dirty_mem[index_i][w],
                                                tag_mem[index_i][w]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            tag_q       <= '0;
        end else begin
            rsp_valid_q <= req_fire;
            if (req_fire) begin
                rdata_q <= rd_entries;
                tag_q   <= tag_i;
            end
        end
    end

    // Compare runs on the held response registers, so hits hold along with rdata.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_way[w] = rdata_q[w*ENT_W + ENT_W - 1] &&
                         (rdata_q[w*ENT_W +: TAG_WIDTH] == tag_q);
        end
    end

    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rdata_o     = rdata_q;
    assign hit_way_o   = hit_way;
    assign hit_o       = |hit_way;

endmodule

// File: tb/tb_dcache_tag_array.sv
// Bench for dcache_tag_array: set-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dcache_tag_array;

    localparam int NW = 2;
    localparam int NS = 8;
    localparam int TW = 20;
    localparam int IW = 3;
    localparam int EW = TW + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_i;
    logic              req_ready_o;
    logic [IW-1:0]     index_i;
    logic [TW-1:0]     tag_i;
    logic [NW-1:0]     wr_en_i;
    logic [TW-1:0]     wtag_i;
    logic              wvalid_i;
    logic              wdirty_i;
    logic              flush_i;
    logic              busy_o;
    logic              rsp_valid_o;
    logic              hit_o;
    logic [NW-1:0]     hit_way_o;
    logic [NW*EW-1:0]  rdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    dcache_tag_array #(
        .NUM_WAYS (NW),
        .NUM_SETS (NS),
        .TAG_WIDTH(TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .req_ready_o(req_ready_o),
        .index_i    (index_i),
        .tag_i      (tag_i),
        .wr_en_i    (wr_en_i),
        .wtag_i     (wtag_i),
        .wvalid_i   (wvalid_i),
        .wdirty_i   (wdirty_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .rsp_valid_o(rsp_valid_o),
        .hit_o      (hit_o),
        .hit_way_o  (hit_way_o),
        .rdata_o    (rdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-entry contents, sweep progress, expected response.
    logic          m_valid [NS][NW];
    logic          m_dirty [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];
    logic          m_known [NS][NW];
    int            sweep_left = NS;
    logic          cmp_en = 1'b0;
    logic             exp_rsp = 1'b0;
    logic [NW*EW-1:0] exp_rdata = '0;
    logic [NW*EW-1:0] exp_mask = '1;
    logic [NW-1:0]    exp_hit_way = '0;

    initial begin
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_known[s][w] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        cmp_en = 1'b1;
        if (rst) begin
            sweep_left  = NS;
            exp_rsp     = 1'b0;
            exp_rdata   = '0;
            exp_mask    = '1;
            exp_hit_way = '0;
        end else begin
            exp_rsp = 1'b0;
            if (sweep_left > 0) begin
                for (int w = 0; w < NW; w++) begin
                    m_valid[NS - sweep_left][w] = 1'b0;
                    m_dirty[NS - sweep_left][w] = 1'b0;
                end
                sweep_left--;
            end else if (flush_i) begin
                sweep_left = NS;
            end else if (req_i) begin
                exp_rsp     = 1'b1;
                exp_hit_way = '0;
                for (int w = 0; w < NW; w++) begin
                    if (wr_en_i[w]) begin
                        m_valid[index_i][w] = wvalid_i;
                        m_dirty[index_i][w] = wdirty_i;
                        m_tag[index_i][w]   = wtag_i;
                        m_known[index_i][w] = 1'b1;
                    end
                    exp_rdata[w*EW +: EW] = {m_valid[index_i][w], m_dirty[index_i][w], m_tag[index_i][w]};
                    exp_mask[w*EW +: EW]  = m_known[index_i][w] ? {EW{1'b1}} : {2'b11, {TW{1'b0}}};
                    if (m_valid[index_i][w] && m_tag[index_i][w] == tag_i) exp_hit_way[w] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (cmp_en) begin
            check("busy", busy_o, sweep_left > 0);
            check("req_ready", req_ready_o, (sweep_left == 0) && !flush_i && !rst);
            check("rsp_valid", rsp_valid_o, exp_rsp);
            check("hit_way", hit_way_o, exp_hit_way);
            check("hit", hit_o, |exp_hit_way);
            check("rdata", rdata_o & exp_mask, exp_rdata & exp_mask);
        end
    end

    task automatic do_req(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                          input logic [NW-1:0] wr, input logic [TW-1:0] wtag,
                          input logic wv, input logic wd);
        index_i  = idx;
        tag_i    = tag;
        wr_en_i  = wr;
        wtag_i   = wtag;
        wvalid_i = wv;
        wdirty_i = wd;
        req_i    = 1'b1;
        @(negedge clk);
        req_i   = 1'b0;
        wr_en_i = '0;
    endtask

    task automatic count_busy(output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (busy_o && n < 100) begin
            n++;
            if (rsp_valid_o) pulses++;
            @(negedge clk);
        end
    endtask

    int nb;
    int np;

    initial begin
        rst = 1'b1; req_i = 1'b0; index_i = '0; tag_i = '0; wr_en_i = '0;
        wtag_i = '0; wvalid_i = 1'b0; wdirty_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy_o, 1);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_rdata", rdata_o, 0);
        rst = 1'b0;

        count_busy(nb, np);
        check("init_busy_cycles", nb, 8);
        for (int s = 0; s < NS; s++) begin
            do_req(IW'(s), 20'h0, 2'b00, 20'h0, 1'b0, 1'b0);
            check("init_lookup_hit", hit_o, 0);
            check("init_lookup_valids", {rdata_o[43], rdata_o[21]}, 2'b00);
        end

        do_req(3'd3, 20'h0, 2'b10, 20'hABCDE, 1'b1, 1'b0);
        do_req(3'd3, 20'hABCDE, 2'b00, 20'h0, 1'b0, 1'b0);
        check("set3_hit_way", hit_way_o, 2'b10);
        check("set3_hit", hit_o, 1);
        do_req(3'd3, 20'hABCDF, 2'b00, 20'h0, 1'b0, 1'b0);
        check("set3_miss", hit_o, 0);

        do_req(3'd5, 20'h12345, 2'b01, 20'h12345, 1'b1, 1'b1);
        check("wfirst_hit_way", hit_way_o, 2'b01);
        check("wfirst_dirty", rdata_o[20], 1);

        index_i = 3'd2; tag_i = 20'h0; wr_en_i = 2'b01; wtag_i = 20'h55555;
        wvalid_i = 1'b1; wdirty_i = 1'b0; req_i = 1'b1;
        @(negedge clk);
        wr_en_i = 2'b00; tag_i = 20'h55555;
        @(negedge clk);
        req_i = 1'b0;
        check("b2b_rsp_valid", rsp_valid_o, 1);
        check("b2b_hit_way", hit_way_o, 2'b01);
        check("b2b_tag", rdata_o[19:0], 20'h55555);
        @(negedge clk);

        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                do_req(IW'(s), 20'h0, 2'(1 << w), 20'h10000 + 20'(s * 16 + w), 1'b1, w[0]);
            end
        end
        do_req(3'd6, 20'h10061, 2'b00, 20'h0, 1'b0, 1'b0);
        check("fill_hit_way", hit_way_o, 2'b10);

        flush_i = 1'b1; req_i = 1'b1; index_i = 3'd1; tag_i = 20'h10010;
        #1;
        check("flush_req_ready", req_ready_o, 0);
        @(negedge clk);
        flush_i = 1'b0; req_i = 1'b0;
        check("flush_no_rsp", rsp_valid_o, 0);
        count_busy(nb, np);
        check("flush_busy_cycles", nb, 8);
        for (int s = 0; s < NS; s++) begin
            do_req(IW'(s), 20'h10000 + 20'(s * 16), 2'b00, 20'h0, 1'b0, 1'b0);
            check("flush_lookup_miss", hit_o, 0);
            check("flush_tag_w0", rdata_o[19:0], 20'h10000 + 20'(s * 16));
            check("flush_tag_w1", rdata_o[41:22], 20'h10000 + 20'(s * 16 + 1));
        end

        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_busy(nb, np);
        check("rst_midflush_busy_cycles", nb, 8);
        check("rst_midflush_pulses", np, 0);
        for (int s = 0; s < NS; s++) begin
            do_req(IW'(s), 20'h10000 + 20'(s * 16 + 1), 2'b00, 20'h0, 1'b0, 1'b0);
            check("post_rst_miss", hit_o, 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_tag_array.md
# dcache_tag_array

Parametrised multi-way tag store for the write-back data cache. It holds one `{valid, dirty, tag}` entry per way per set and performs a registered tag lookup with hit detection. It supports masked per-way writes with write-first read-back, and runs a sequential invalidate-all sweep after reset and on a flush request. The block sits between the dcache controller FSM and the data RAM, replacing the single-way tag RAM with its asynchronous valid clear.

## Interface
Parameters:
- `NUM_WAYS`, 2: number of ways; ≥1.
- `NUM_SETS`, 64: number of sets; power of two, ≥2.
- `TAG_WIDTH`, 20: tag bits per entry.
- `IDX_W`, `$clog2(NUM_SETS)`: set index width (derived).
- `ENT_W`, `TAG_WIDTH+2`: entry width, packed `{valid, dirty, tag}` with valid at the MSB (derived).

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_i`, in, 1: lookup/write request.
- `req_ready_o`, out, 1: request accepted when `req_i && req_ready_o`; equals `(state==IDLE) && !flush_i`.
- `index_i`, in, IDX_W: set index.
- `tag_i`, in, TAG_WIDTH: compare tag.
- `wr_en_i`, in, NUM_WAYS: way write mask; all zero means a pure lookup.
- `wtag_i`, in, TAG_WIDTH: tag to write.
- `wvalid_i`, in, 1: valid bit to write.
- `wdirty_i`, in, 1: dirty bit to write.
- `flush_i`, in, 1: start invalidate-all; level sampled in IDLE only.
- `busy_o`, out, 1: registered; high while an INIT or FLUSH sweep is in progress.
- `rsp_valid_o`, out, 1: response strobe, one cycle after an accepted request.
- `hit_o`, out, 1: OR of `hit_way_o`.
- `hit_way_o`, out, NUM_WAYS: per-way hit vector.
- `rdata_o`, out, NUM_WAYS*ENT_W: all way entries of the set; way w occupies `[w*ENT_W +: ENT_W]`.

## Operation
- States: INIT, FLUSH, IDLE.
- `rst` → INIT with sweep counter `cnt` = 0. INIT and FLUSH behave identically; the two states exist only for debug visibility.
- In INIT or FLUSH, each cycle clears the valid and dirty bits of every way at set `cnt`; tag bits are untouched. Then `cnt` increments. When `cnt == NUM_SETS-1` is cleared, the next state is IDLE and `cnt` returns to 0.
- IDLE with `flush_i` = 1 → FLUSH. The same-cycle `req_i` is not accepted, because `req_ready_o` is 0 and flush wins.
- `flush_i` outside IDLE is ignored; it is not queued.
- Accepted request:
  - Read all ways at `index_i`.
  - For each way with `wr_en_i[w]` = 1, write `{wvalid_i, wdirty_i, wtag_i}`. Write-first: the written value appears on `rdata_o` for that way.
  - Register `tag_i` for the compare.
- Hit: `hit_way_o[w] = rdata_o[w].valid && (rdata_o[w].tag == tag_q)`, evaluated on the response cycle, so it reflects write-first data.
- Multiple hits are illegal for the controller to create, but all are reported unmasked.
- Back-to-back requests, one per cycle, are supported. A request to the set written in the previous cycle sees the new data.
- `rst` asserted mid-sweep or mid-request aborts the operation: the response is dropped, and the sweep restarts at set 0.

## Timing
- Reset values:
  - `busy_o` = 1 (registered from state), `rsp_valid_o` = 0, `hit_o` = 0, `hit_way_o` = 0, `rdata_o` = 0.
  - `req_ready_o` = 0 while `rst` is high.
- After `rst` falls, sets 0..NUM_SETS-1 are cleared in cycles 1..NUM_SETS. `busy_o` falls and `req_ready_o` rises in cycle NUM_SETS+1.
- Flush accepted at edge T: `busy_o` is high from T+1 to T+NUM_SETS, and the block is ready again at T+NUM_SETS+1.
- Request accepted at edge T: `rsp_valid_o`, `hit_o`, `hit_way_o`, and `rdata_o` are valid in cycle T+1. `rsp_valid_o` is a single-cycle pulse per request.
- When no response is pending, `rsp_valid_o` = 0. `rdata_o`, `hit_o`, and `hit_way_o` hold their last values.
- During a sweep, `rsp_valid_o` stays 0.

## Test plan
Bench configuration: NUM_WAYS=2, NUM_SETS=8, TAG_WIDTH=20.
- Reset release: count `busy_o` high cycles = 8. Then lookups of sets 0..7 with any tag → `hit_o` = 0 and all valid bits 0.
- Write set 3, way 1, `{1,0,0xABCDE}`, followed by a lookup of set 3 with tag 0xABCDE → `hit_way_o` = 2'b10, `hit_o` = 1. A lookup with tag 0xABCDF → `hit_o` = 0.
- Write-first: lookup set 5, tag 0x12345, with `wr_en_i` = 2'b01 writing `{1,1,0x12345}` → the same response shows `hit_way_o` = 2'b01 and way-0 dirty = 1.
- Flush: fill sets 0..7, assert `flush_i` together with `req_i` in IDLE → req not accepted, `busy_o` high for 8 cycles. All subsequent lookups miss, and tags read back unchanged.
- Reset mid-flush: assert `rst` at `cnt` = 4 → INIT restarts at set 0, `busy_o` high for 8 cycles after release, and no `rsp_valid_o` pulses.
- Back-to-back: write set 2 then look up set 2 in the next cycle → the second response hits with the new tag.
